mem_stage_sb: RTL and testbench

- Parametrised successor of the MEM pipeline stage: the data-memory access stage plus the MEM/WB stage register.
- Adds byte/halfword/word accesses with sign/zero extension and misalignment detection.
- Adds a SB_DEPTH-entry posted store buffer that drains to the data cache. Loads are forwarded from the buffer when the youngest matching entry fully covers them.
- Raises a stall to the hazard unit on load waits, store-buffer conflicts, and store-buffer full.

---
 rtl/mem_stage_sb.sv | 188 ++++++++++++++++++
 tb/tb_mem_stage_sb.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_sb.sv
// MEM pipeline stage with sized/extended data-memory access, a posted store buffer
// with youngest-match load forwarding, and the MEM/WB stage register.
module mem_stage_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int REG_W    = 5,
  parameter int SB_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  en_reg,
  input  logic                  wb_en_in,
  input  logic                  mem_r_en_in,
  input  logic                  mem_w_en_in,
  input  logic [1:0]            mem_size_in,
  input  logic                  mem_unsigned_in,
  input  logic [ADDR_W-1:0]     addr_in,
  input  logic [DATA_W-1:0]     store_data_in,
  input  logic [REG_W-1:0]      regd_in,
  input  logic [ADDR_W-1:0]     pcnext_in,
  input  logic                  is_branch_in,
  input  logic                  zero_in,
  output logic                  branch_taken,
  output logic                  stall,
  output logic                  wb_en,
  output logic                  mem_to_reg,
  output logic [DATA_W-1:0]     read_data,
  output logic [ADDR_W-1:0]     alu_result,
  output logic [ADDR_W-1:0]     pcnext,
  output logic [REG_W-1:0]      regd,
  output logic                  misaligned_exc,
  output logic                  dc_rd_req,
  output logic [ADDR_W-1:0]     dc_rd_addr,
  input  logic [DATA_W-1:0]     dc_rd_data,
  input  logic                  dc_rd_valid,
  output logic                  dc_wr_req,
  output logic [ADDR_W-1:0]     dc_wr_addr,
  output logic [DATA_W-1:0]     dc_wr_data,
  output logic [DATA_W/8-1:0]   dc_wr_be,
  input  logic                  dc_wr_ack
);
  localparam int BE_W   = DATA_W / 8;
  localparam int LANE_W = $clog2(BE_W);
  localparam int PTR_W  = $clog2(SB_DEPTH);
  localparam logic [PTR_W:0] SB_FULL = (PTR_W+1)'(SB_DEPTH);

  logic [LANE_W-1:0] w_lane;
  logic [LANE_W+2:0] w_shamt;
  logic              w_byte, w_half, w_word, w_mis;
  logic              w_store, w_load;
  logic [ADDR_W-1:0] w_word_addr;
  logic [BE_W-1:0]   w_acc_be;
  logic [DATA_W-1:0] w_st_data;

  assign branch_taken = is_branch_in & zero_in;

  assign w_lane      = addr_in[LANE_W-1:0];
  assign w_shamt     = {w_lane, 3'b000};
  assign w_byte      = (mem_size_in == 2'b00);
  assign w_half      = (mem_size_in == 2'b01);
  assign w_word      = mem_size_in[1];
  // Only real memory accesses can be misaligned; ALU results are arbitrary.
  assign w_mis       = (mem_r_en_in | mem_w_en_in) &
                       ((w_half & w_lane[0]) | (w_word & (w_lane != '0)));
  assign w_store     = mem_w_en_in & ~w_mis & ~flush;
  assign w_load      = mem_r_en_in & ~mem_w_en_in & ~w_mis & ~flush;
  assign w_word_addr = {addr_in[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};

  always_comb begin
    w_acc_be  = '1;
    w_st_data = store_data_in;
    if (w_byte) begin
      w_acc_be  = BE_W'(1) << w_lane;
      w_st_data = DATA_W'(store_data_in[7:0]) << w_shamt;
    end else if (w_half) begin
      w_acc_be  = BE_W'(3) << w_lane;
      w_st_data = DATA_W'(store_data_in[15:0]) << w_shamt;
    end
  end

  logic [ADDR_W-1:0] r_sb_addr [SB_DEPTH];
  logic [DATA_W-1:0] r_sb_data [SB_DEPTH];
  logic [BE_W-1:0]   r_sb_be   [SB_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
  logic [PTR_W:0]    r_count;

  logic [SB_DEPTH-1:0] w_match;
  for (genvar gi = 0; gi < SB_DEPTH; gi++) begin : g_match
    logic [PTR_W-1:0] w_age;
    assign w_age        = PTR_W'(gi) - r_rd_ptr;
    assign w_match[gi]  = ({1'b0, w_age} < r_count) && (r_sb_addr[gi] == w_word_addr);
  end

  logic             w_hit;
  logic [PTR_W-1:0] w_hit_idx;
  // Scan oldest to youngest so the last match wins.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = '0;
    for (int k = 0; k < SB_DEPTH; k++) begin
      if (w_match[r_rd_ptr + PTR_W'(k)]) begin
        w_hit     = 1'b1;
        w_hit_idx = r_rd_ptr + PTR_W'(k);
      end
    end
  end

  logic w_cover, w_fwd, w_conflict, w_cache, w_full, w_adv, w_enq, w_pop;
  assign w_cover    = ((r_sb_be[w_hit_idx] & w_acc_be) == w_acc_be);
  assign w_fwd      = w_load & w_hit & w_cover;
  assign w_conflict = w_load & w_hit & ~w_cover;
  assign w_cache    = w_load & ~w_hit;
  assign w_full     = (r_count == SB_FULL);
  assign stall      = w_conflict | (w_cache & ~dc_rd_valid) | (w_store & w_full & ~dc_wr_ack);
  assign w_adv      = en_reg & ~stall;
  assign w_enq      = w_store & w_adv;
  assign w_pop      = (r_count != '0) & dc_wr_ack;

  assign dc_rd_req  = w_cache;
  assign dc_rd_addr = w_word_addr;
  assign dc_wr_req  = (r_count != '0);
  assign dc_wr_addr = r_sb_addr[r_rd_ptr];
  assign dc_wr_data = r_sb_data[r_rd_ptr];
  assign dc_wr_be   = r_sb_be[r_rd_ptr];

  logic [DATA_W-1:0] w_raw, w_shifted, w_ext;
  assign w_raw     = w_fwd ? r_sb_data[w_hit_idx] : dc_rd_data;
  assign w_shifted = w_raw >> w_shamt;

  always_comb begin
    w_ext = w_shifted;
    if (w_byte) begin
      w_ext = mem_unsigned_in ? DATA_W'(w_shifted[7:0]) : DATA_W'($signed(w_shifted[7:0]));
    end else if (w_half) begin
      w_ext = mem_unsigned_in ? DATA_W'(w_shifted[15:0]) : DATA_W'($signed(w_shifted[15:0]));
    end
  end

  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_sb_addr[r_wr_ptr] <= w_word_addr;
      r_sb_data[r_wr_ptr] <= w_st_data;
      r_sb_be[r_wr_ptr]   <= w_acc_be;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_enq) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_enq && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_enq && w_pop) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_en          <= 1'b0;
      mem_to_reg     <= 1'b0;
      read_data      <= '0;
      alu_result     <= '0;
      pcnext         <= '0;
      regd           <= '0;
      misaligned_exc <= 1'b0;
    end else if (en_reg && flush) begin
      wb_en          <= 1'b0;
      mem_to_reg     <= 1'b0;
      read_data      <= '0;
      alu_result     <= '0;
      pcnext         <= '0;
      regd           <= '0;
      misaligned_exc <= 1'b0;
    end else if (w_adv) begin
      wb_en          <= wb_en_in & ~w_mis;
      mem_to_reg     <= mem_r_en_in & ~mem_w_en_in;
      read_data      <= w_load ? w_ext : '0;
      alu_result     <= addr_in;
      pcnext         <= pcnext_in;
      regd           <= regd_in;
      misaligned_exc <= w_mis;
    end
  end
endmodule

// File: tb/tb_mem_stage_sb.sv
// Scoreboard bench for mem_stage_sb: directed instructions push expected stage and
// cache-write results; monitors pop and compare as the DUT retires or drains.
module tb_mem_stage_sb;
  logic        clk = 1'b0;
  logic        reset, flush, en_reg, wb_en_in, mem_r_en_in, mem_w_en_in;
  logic [1:0]  mem_size_in;
  logic        mem_unsigned_in, is_branch_in, zero_in;
  logic [31:0] addr_in, store_data_in, pcnext_in;
  logic [4:0]  regd_in;
  logic        branch_taken, stall, wb_en, mem_to_reg, misaligned_exc;
  logic [31:0] read_data, alu_result, pcnext;
  logic [4:0]  regd;
  logic        dc_rd_req, dc_rd_valid, dc_wr_req, dc_wr_ack;
  logic [31:0] dc_rd_addr, dc_rd_data, dc_wr_addr, dc_wr_data;
  logic [3:0]  dc_wr_be;

  mem_stage_sb dut (
    .clk(clk), .reset(reset), .flush(flush), .en_reg(en_reg), .wb_en_in(wb_en_in),
    .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in), .mem_size_in(mem_size_in),
    .mem_unsigned_in(mem_unsigned_in), .addr_in(addr_in), .store_data_in(store_data_in),
    .regd_in(regd_in), .pcnext_in(pcnext_in), .is_branch_in(is_branch_in), .zero_in(zero_in),
    .branch_taken(branch_taken), .stall(stall), .wb_en(wb_en), .mem_to_reg(mem_to_reg),
    .read_data(read_data), .alu_result(alu_result), .pcnext(pcnext), .regd(regd),
    .misaligned_exc(misaligned_exc), .dc_rd_req(dc_rd_req), .dc_rd_addr(dc_rd_addr),
    .dc_rd_data(dc_rd_data), .dc_rd_valid(dc_rd_valid), .dc_wr_req(dc_wr_req),
    .dc_wr_addr(dc_wr_addr), .dc_wr_data(dc_wr_data), .dc_wr_be(dc_wr_be), .dc_wr_ack(dc_wr_ack)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic wb; logic m2r; logic [31:0] rd; logic [31:0] alu; logic [31:0] pc; logic [4:0] regd; logic mis;
  } exp_t;
  typedef struct packed { logic [31:0] a; logic [31:0] d; logic [3:0] be; } wexp_t;

  exp_t  sq[$];
  wexp_t wq[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    seq     = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Stage monitor: an advance decided before the edge retires one expected entry.
  initial begin
    logic a;
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      a = en_reg && !stall && reset;
      @(posedge clk);
      #1;
      if (a) begin
        if (sq.size() == 0) begin
          chk("retire_unexpected", 32'd1, 32'd0);
        end else begin
          e = sq.pop_front();
          chk("wb_en", {31'd0, wb_en}, {31'd0, e.wb});
          chk("mem_to_reg", {31'd0, mem_to_reg}, {31'd0, e.m2r});
          chk("read_data", read_data, e.rd);
          chk("alu_result", alu_result, e.alu);
          chk("pcnext", pcnext, e.pc);
          chk("regd", {27'd0, regd}, {27'd0, e.regd});
          chk("misaligned_exc", {31'd0, misaligned_exc}, {31'd0, e.mis});
          $display("[TB] retire pc=%h alu=%h read_data=%h mis=%0d", pcnext, alu_result, read_data, misaligned_exc);
        end
      end
    end
  end

  // Drain monitor: every accepted cache write must match the next queued store.
  initial begin
    wexp_t w;
    forever begin
      @(negedge clk);
      #3;
      if (dc_wr_req && dc_wr_ack) begin
        if (wq.size() == 0) begin
          chk("write_unexpected", 32'd1, 32'd0);
        end else begin
          w = wq.pop_front();
          chk("wr_addr", dc_wr_addr, w.a);
          chk("wr_data", dc_wr_data, w.d);
          chk("wr_be", {28'd0, dc_wr_be}, {28'd0, w.be});
          $display("[TB] drain addr=%h data=%h be=%b", dc_wr_addr, dc_wr_data, dc_wr_be);
        end
      end
    end
  end

  task automatic issue(input logic r, input logic w, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] sdata, input logic [31:0] rdata,
                       input int lat, input int ack_at, input int flush_at,
                       input logic [31:0] exp_rd, input logic exp_mis, input int exp_stall,
                       input logic exp_req0, input logic [31:0] exp_wd, input logic [3:0] exp_be);
    int   cyc = 0;
    int   st  = 0;
    exp_t e;
    seq++;
    mem_r_en_in = r; mem_w_en_in = w; mem_size_in = sz; mem_unsigned_in = uns;
    addr_in = addr; store_data_in = sdata; regd_in = seq[4:0];
    pcnext_in = 32'h1000 + seq * 4; wb_en_in = !w; dc_rd_data = rdata; en_reg = 1'b1;
    forever begin
      dc_rd_valid = (cyc >= lat);
      if (ack_at >= 0) dc_wr_ack = (cyc == ack_at);
      flush = (flush_at >= 0) && (cyc >= flush_at);
      #1;
      if (cyc == 0) chk("rd_req_first", {31'd0, dc_rd_req}, {31'd0, exp_req0});
      if (flush) begin
        chk("flush_stall", {31'd0, stall}, 32'd0);
        chk("flush_rd_req", {31'd0, dc_rd_req}, 32'd0);
      end
      if (!stall) break;
      st++;
      cyc++;
      if (cyc > 200) begin
        n_fail++;
        $display("FAIL timeout addr=%h actual=stalled required=advance", addr);
        $fatal(1, "stall never released");
      end
      @(negedge clk);
    end
    chk("stall_cycles", st, exp_stall);
    if (flush) e = '0;
    else e = '{wb: (!w && !exp_mis), m2r: (r && !w), rd: exp_rd, alu: addr, pc: pcnext_in,
               regd: regd_in, mis: exp_mis};
    sq.push_back(e);
    if (w && !exp_mis && !flush) wq.push_back('{a: {addr[31:2], 2'b00}, d: exp_wd, be: exp_be});
    @(posedge clk);
    @(negedge clk);
    en_reg = 1'b0; mem_r_en_in = 1'b0; mem_w_en_in = 1'b0; flush = 1'b0; dc_rd_valid = 1'b0;
    if (ack_at >= 0) dc_wr_ack = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    dc_wr_ack = 1'b1;
    #1;
    while (dc_wr_req && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("drain_done", {31'd0, dc_wr_req}, 32'd0);
    dc_wr_ack = 1'b0;
    chk("write_queue_empty", wq.size(), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; en_reg = 1'b0; wb_en_in = 1'b0; mem_r_en_in = 1'b0;
    mem_w_en_in = 1'b0; mem_size_in = 2'b10; mem_unsigned_in = 1'b0; addr_in = '0;
    store_data_in = '0; regd_in = '0; pcnext_in = '0; is_branch_in = 1'b0; zero_in = 1'b0;
    dc_rd_data = '0; dc_rd_valid = 1'b0; dc_wr_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_wb_en", {31'd0, wb_en}, 32'd0);
    chk("rst_read_data", read_data, 32'd0);
    chk("rst_alu_result", alu_result, 32'd0);
    chk("rst_dc_wr_req", {31'd0, dc_wr_req}, 32'd0);
    chk("rst_dc_rd_req", {31'd0, dc_rd_req}, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    is_branch_in = 1'b1; zero_in = 1'b1; #1;
    chk("branch_taken_11", {31'd0, branch_taken}, 32'd1);
    zero_in = 1'b0; #1;
    chk("branch_taken_10", {31'd0, branch_taken}, 32'd0);
    is_branch_in = 1'b0; zero_in = 1'b1; #1;
    chk("branch_taken_01", {31'd0, branch_taken}, 32'd0);
    zero_in = 1'b0;
    @(negedge clk);

    // Sized loads from the cache word 0x80FF7F01
    issue(1, 0, 2'b00, 0, 32'h101, 0, 32'h80FF7F01, 0, -1, -1, 32'h0000007F, 0, 0, 1, 0, 0);
    issue(1, 0, 2'b00, 0, 32'h102, 0, 32'h80FF7F01, 0, -1, -1, 32'hFFFFFFFF, 0, 0, 1, 0, 0);
    issue(1, 0, 2'b00, 1, 32'h103, 0, 32'h80FF7F01, 0, -1, -1, 32'h00000080, 0, 0, 1, 0, 0);
    issue(1, 0, 2'b01, 0, 32'h102, 0, 32'h80FF7F01, 0, -1, -1, 32'hFFFF80FF, 0, 0, 1, 0, 0);
    issue(1, 0, 2'b10, 0, 32'h100, 0, 32'h80FF7F01, 2, -1, -1, 32'h80FF7F01, 0, 2, 1, 0, 0);

    // Misaligned accesses, including size 11 treated as word
    issue(1, 0, 2'b10, 0, 32'h102, 0, 0, 99, -1, -1, 0, 1, 0, 0, 0, 0);
    issue(1, 0, 2'b11, 0, 32'h101, 0, 0, 99, -1, -1, 0, 1, 0, 0, 0, 0);
    issue(0, 1, 2'b01, 0, 32'h201, 32'h1234, 0, 0, -1, -1, 0, 1, 0, 0, 0, 0);

    // Forwarding from a held store
    issue(0, 1, 2'b10, 0, 32'h200, 32'hDEADBEEF, 0, 0, -1, -1, 0, 0, 0, 0, 32'hDEADBEEF, 4'hF);
    issue(1, 0, 2'b01, 0, 32'h202, 0, 0, 99, -1, -1, 32'hFFFFDEAD, 0, 0, 0, 0, 0);
    issue(1, 0, 2'b00, 1, 32'h200, 0, 0, 99, -1, -1, 32'h000000EF, 0, 0, 0, 0, 0);
    drain();

    // Youngest match wins
    issue(0, 1, 2'b10, 0, 32'h600, 32'h11111111, 0, 0, -1, -1, 0, 0, 0, 0, 32'h11111111, 4'hF);
    issue(0, 1, 2'b00, 0, 32'h600, 32'h22, 0, 0, -1, -1, 0, 0, 0, 0, 32'h00000022, 4'h1);
    issue(1, 0, 2'b00, 0, 32'h600, 0, 0, 99, -1, -1, 32'h00000022, 0, 0, 0, 0, 0);
    drain();

    // Lane placement of sub-word stores
    issue(0, 1, 2'b01, 0, 32'h502, 32'hFFFF1234, 0, 0, -1, -1, 0, 0, 0, 0, 32'h12340000, 4'hC);
    issue(0, 1, 2'b00, 0, 32'h503, 32'hFFFFFFAB, 0, 0, -1, -1, 0, 0, 0, 0, 32'hAB000000, 4'h8);
    drain();

    // Partial-coverage conflict resolved by the drain, then a cache read
    issue(0, 1, 2'b00, 0, 32'h300, 32'h55, 0, 0, -1, -1, 0, 0, 0, 0, 32'h00000055, 4'h1);
    issue(1, 0, 2'b10, 0, 32'h300, 0, 32'hCAFEF00D, 3, 2, -1, 32'hCAFEF00D, 0, 3, 0, 0, 0);

    // Full buffer: the fifth store waits for an ack
    for (int i = 0; i < 4; i++) begin
      issue(0, 1, 2'b10, 0, 32'h400 + i * 4, 32'hA0 + i, 0, 0, -1, -1, 0, 0, 0, 0, 32'hA0 + i, 4'hF);
    end
    issue(0, 1, 2'b10, 0, 32'h410, 32'hA4, 0, 0, 2, -1, 0, 0, 2, 0, 32'hA4, 4'hF);
    drain();

    // Flush a waiting load, then a late valid on a non-load is ignored
    issue(1, 0, 2'b10, 0, 32'h104, 0, 32'h12345678, 99, -1, 2, 0, 0, 2, 1, 0, 0);
    issue(0, 0, 2'b10, 0, 32'h55, 0, 32'hFFFFFFFF, 0, -1, -1, 0, 0, 0, 0, 0, 0);

    // Asynchronous reset while stores are buffered
    issue(0, 1, 2'b10, 0, 32'h700, 32'h7, 0, 0, -1, -1, 0, 0, 0, 0, 32'h7, 4'hF);
    issue(0, 1, 2'b10, 0, 32'h704, 32'h8, 0, 0, -1, -1, 0, 0, 0, 0, 32'h8, 4'hF);
    issue(0, 1, 2'b10, 0, 32'h708, 32'h9, 0, 0, -1, -1, 0, 0, 0, 0, 32'h9, 4'hF);
    chk("sb_pending", {31'd0, dc_wr_req}, 32'd1);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_wr_req", {31'd0, dc_wr_req}, 32'd0);
    chk("async_rst_alu_result", alu_result, 32'd0);
    chk("async_rst_pcnext", pcnext, 32'd0);
    chk("async_rst_regd", {27'd0, regd}, 32'd0);
    wq.delete();
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("post_rst_wr_req", {31'd0, dc_wr_req}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("stage_queue_empty", sq.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
